// File: rtl/switch_agg_demux.sv
// Write-side aggregate demux: assembles a stream of 3-bit lanes into one of
// two 3-lane register banks selected by the registered bank-select `state`.
module switch_agg_demux (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       wr_en,
    input  logic [2:0] wr_data,
    input  logic       clr_0,
    input  logic       clr_1,
    output logic [2:0] bank0_0,
    output logic [2:0] bank0_1,
    output logic [2:0] bank0_2,
    output logic [2:0] bank1_0,
    output logic [2:0] bank1_1,
    output logic [2:0] bank1_2,
    output logic       done_0,
    output logic       done_1,
    output logic [1:0] lane,
    output logic       state,
    output logic       abort
);

    localparam int unsigned LANE_W    = 3;
    localparam int unsigned LANES     = 3;
    localparam int unsigned BANKS     = 2;
    localparam logic [1:0]  LAST_LANE = 2'(LANES - 1);

    logic [BANKS-1:0][LANES-1:0][LANE_W-1:0] bank_q, bank_d;
    logic [BANKS-1:0]                        done_q, done_d;
    logic [1:0]                              lane_q, lane_d;
    logic                                    state_q, state_d;
    logic                                    abort_q, abort_d;

    // Next-state: write into the current bank, then let a bank switch override the lane pointer.
    always_comb begin
        state_d = in;
        lane_d  = lane_q;
        bank_d  = bank_q;
        done_d  = done_q;
        abort_d = 1'b0;

        if (clr_0) done_d[0] = 1'b0;
        if (clr_1) done_d[1] = 1'b0;

        if (wr_en) begin
            bank_d[state_q][lane_q] = wr_data;
            if (lane_q == LAST_LANE) begin
                lane_d          = 2'd0;
                done_d[state_q] = 1'b1;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end

        // A switch abandons a partial aggregate unless this edge completed it.
        if (in != state_q) begin
            lane_d  = 2'd0;
            abort_d = (lane_q != 2'd0) && !(wr_en && (lane_q == LAST_LANE));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q  <= '0;
            done_q  <= '0;
            lane_q  <= 2'd0;
            state_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            done_q  <= done_d;
            lane_q  <= lane_d;
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

    assign bank0_0 = bank_q[0][0];
    assign bank0_1 = bank_q[0][1];
    assign bank0_2 = bank_q[0][2];
    assign bank1_0 = bank_q[1][0];
    assign bank1_1 = bank_q[1][1];
    assign bank1_2 = bank_q[1][2];
    assign done_0  = done_q[0];
    assign done_1  = done_q[1];
    assign lane    = lane_q;
    assign state   = state_q;
    assign abort   = abort_q;

endmodule

// File: tb/tb_switch_agg_demux.sv
// Directed bench for switch_agg_demux: hand-computed expectations per scenario.
module tb_switch_agg_demux;

    logic       clk = 1'b0;
    logic       rst, in_sel, wr_en, clr_0, clr_1;
    logic [2:0] wr_data;
    logic [2:0] bank0_0, bank0_1, bank0_2, bank1_0, bank1_1, bank1_2;
    logic       done_0, done_1, state, abort;
    logic [1:0] lane;

    int errors = 0;
    int checks = 0;

    switch_agg_demux dut (
        .clk(clk), .rst(rst), .in(in_sel), .wr_en(wr_en), .wr_data(wr_data),
        .clr_0(clr_0), .clr_1(clr_1),
        .bank0_0(bank0_0), .bank0_1(bank0_1), .bank0_2(bank0_2),
        .bank1_0(bank1_0), .bank1_1(bank1_1), .bank1_2(bank1_2),
        .done_0(done_0), .done_1(done_1), .lane(lane), .state(state), .abort(abort)
    );

    always #5 clk = ~clk;

    wire [8:0] b0 = {bank0_0, bank0_1, bank0_2};
    wire [8:0] b1 = {bank1_0, bank1_1, bank1_2};
    // {done_1, done_0, state, lane, abort}
    wire [5:0] ctl = {done_1, done_0, state, lane, abort};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_sel = 1'b1; wr_en = 1'b1; wr_data = 3'h7; clr_0 = 1'b0; clr_1 = 1'b0;
        step(); step();
        checks++; if (b0 !== 9'o000) begin errors++; $display("FAIL reset_b0 got %o exp 000", b0); end
        checks++; if (b1 !== 9'o000) begin errors++; $display("FAIL reset_b1 got %o exp 000", b1); end
        checks++; if (ctl !== 6'b00_0_00_0) begin errors++; $display("FAIL reset_ctl got %b exp 000000", ctl); end
        rst = 1'b0; in_sel = 1'b0; wr_en = 1'b0;
        step();
    endtask

    task automatic test_fill_bank0();
        wr(3'h1);
        checks++; if ({bank0_0, lane} !== {3'h1, 2'd1}) begin errors++; $display("FAIL fill0_lat got %h/%0d exp 1/1", bank0_0, lane); end
        step();
        checks++; if (lane !== 2'd1) begin errors++; $display("FAIL fill0_idle_hold got %0d exp 1", lane); end
        wr(3'h2);
        wr(3'h3);
        checks++; if (b0 !== 9'o123) begin errors++; $display("FAIL fill0_b0 got %o exp 123", b0); end
        checks++; if (b1 !== 9'o000) begin errors++; $display("FAIL fill0_b1 got %o exp 000", b1); end
        checks++; if (ctl !== 6'b01_0_00_0) begin errors++; $display("FAIL fill0_ctl got %b exp 010000", ctl); end
    endtask

    task automatic test_fill_bank1();
        in_sel = 1'b1;
        step();
        checks++; if (ctl !== 6'b01_1_00_0) begin errors++; $display("FAIL fill1_switch got %b exp 011000", ctl); end
        wr(3'h7); wr(3'h6); wr(3'h5);
        checks++; if (b1 !== 9'o765) begin errors++; $display("FAIL fill1_b1 got %o exp 765", b1); end
        checks++; if (b0 !== 9'o123) begin errors++; $display("FAIL fill1_b0 got %o exp 123", b0); end
        checks++; if (ctl !== 6'b11_1_00_0) begin errors++; $display("FAIL fill1_ctl got %b exp 111000", ctl); end
    endtask

    task automatic test_abort();
        in_sel = 1'b0;
        step();
        wr(3'h4);
        checks++; if ({bank0_0, lane} !== {3'h4, 2'd1}) begin errors++; $display("FAIL abort_pre got %h/%0d exp 4/1", bank0_0, lane); end
        in_sel = 1'b1;
        step();
        checks++; if (ctl !== 6'b11_1_00_1) begin errors++; $display("FAIL abort_pulse got %b exp 111001", ctl); end
        checks++; if (b0 !== 9'o423) begin errors++; $display("FAIL abort_b0 got %o exp 423", b0); end
        step();
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL abort_one_cycle got %b exp 0", abort); end
        // Switch while writing lane 1: write lands in old bank and still aborts.
        wr(3'h3);
        in_sel = 1'b0; wr_en = 1'b1; wr_data = 3'h2;
        step();
        wr_en = 1'b0;
        checks++; if (b1 !== 9'o325) begin errors++; $display("FAIL abort_wr_b1 got %o exp 325", b1); end
        checks++; if (ctl !== 6'b11_0_00_1) begin errors++; $display("FAIL abort_wr_ctl got %b exp 110001", ctl); end
        step();
    endtask

    task automatic test_switch_complete();
        in_sel = 1'b1; clr_1 = 1'b1;
        step();
        clr_1 = 1'b0;
        checks++; if (ctl !== 6'b01_1_00_0) begin errors++; $display("FAIL swc_clear got %b exp 011000", ctl); end
        wr(3'h1); wr(3'h3);
        in_sel = 1'b0; wr_en = 1'b1; wr_data = 3'h2;
        step();
        wr_en = 1'b0;
        checks++; if (b1 !== 9'o132) begin errors++; $display("FAIL swc_b1 got %o exp 132", b1); end
        checks++; if (ctl !== 6'b11_0_00_0) begin errors++; $display("FAIL swc_ctl got %b exp 110000", ctl); end
        step();
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL swc_abort_late got %b exp 0", abort); end
    endtask

    task automatic test_set_vs_clear();
        clr_0 = 1'b1;
        step();
        clr_0 = 1'b0;
        checks++; if (done_0 !== 1'b0) begin errors++; $display("FAIL svc_clr got %b exp 0", done_0); end
        wr(3'h5); wr(3'h6);
        clr_0 = 1'b1;
        wr(3'h7);
        checks++; if ({done_0, b0} !== {1'b1, 9'o567}) begin errors++; $display("FAIL svc_set_wins got %b/%o exp 1/567", done_0, b0); end
        step();
        clr_0 = 1'b0;
        checks++; if (done_0 !== 1'b0) begin errors++; $display("FAIL svc_clr_after got %b exp 0", done_0); end
        wr(3'h1); wr(3'h1); wr(3'h1);
        checks++; if ({done_0, b0} !== {1'b1, 9'o111}) begin errors++; $display("FAIL svc_overwrite got %b/%o exp 1/111", done_0, b0); end
    endtask

    task automatic test_reset_mid();
        wr(3'h3);
        checks++; if (lane !== 2'd1) begin errors++; $display("FAIL rstm_pre got %0d exp 1", lane); end
        rst = 1'b1; wr_en = 1'b1; wr_data = 3'h6; in_sel = 1'b1;
        step();
        rst = 1'b0; wr_en = 1'b0; in_sel = 1'b0;
        checks++; if ({b0, b1} !== 18'o000000) begin errors++; $display("FAIL rstm_banks got %o/%o exp 000/000", b0, b1); end
        checks++; if (ctl !== 6'b00_0_00_0) begin errors++; $display("FAIL rstm_ctl got %b exp 000000", ctl); end
        step();
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL rstm_abort got %b exp 0", abort); end
    endtask

    initial begin
        test_reset();
        test_fill_bank0();
        test_fill_bank1();
        test_abort();
        test_switch_complete();
        test_set_vs_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got stuck exp finish");
        $fatal(1);
    end

endmodule
